// File: rtl/el2_ifu_iccm_access_ctrl_if.sv
// ICCM arbiter bus: fetch/DMA request-grant handshakes, ECC feedback and the
// registered memory command port.
interface el2_ifu_iccm_access_ctrl_if #(
  parameter int unsigned ICCM_BITS = 16
);
  logic                   fetch_req;
  logic [ICCM_BITS-1:1]   fetch_addr;
  logic                   fetch_gnt;
  logic                   dma_req;
  logic                   dma_write;
  logic [ICCM_BITS-1:1]   dma_addr;
  logic [2:0]             dma_size;
  logic [77:0]            dma_wdata;
  logic                   dma_gnt;
  logic                   rd_valid;
  logic                   rd_src;
  logic                   ecc_single_err;
  logic [77:0]            ecc_corr_data;
  logic                   iccm_rden;
  logic                   iccm_wren;
  logic [ICCM_BITS-1:1]   iccm_rw_addr;
  logic [2:0]             iccm_wr_size;
  logic [77:0]            iccm_wr_data;
  logic                   iccm_buf_correct_ecc;
  logic                   iccm_correction_state;
  logic [7:0]             corr_count;
  logic                   corr_dropped;

  modport slave (
    input  fetch_req, fetch_addr, dma_req, dma_write, dma_addr, dma_size,
           dma_wdata, ecc_single_err, ecc_corr_data,
    output fetch_gnt, dma_gnt, rd_valid, rd_src, iccm_rden, iccm_wren,
           iccm_rw_addr, iccm_wr_size, iccm_wr_data, iccm_buf_correct_ecc,
           iccm_correction_state, corr_count, corr_dropped
  );

  modport master (
    output fetch_req, fetch_addr, dma_req, dma_write, dma_addr, dma_size,
           dma_wdata, ecc_single_err, ecc_corr_data,
    input  fetch_gnt, dma_gnt, rd_valid, rd_src, iccm_rden, iccm_wren,
           iccm_rw_addr, iccm_wr_size, iccm_wr_data, iccm_buf_correct_ecc,
           iccm_correction_state, corr_count, corr_dropped
  );
endinterface

// File: rtl/el2_ifu_iccm_access_ctrl.sv
// ICCM access arbiter: DMA-over-fetch priority with starvation limit, and a
// one-cycle write-back of ECC-corrected data after a fetch single-bit error.
module el2_ifu_iccm_access_ctrl #(
  parameter int unsigned ICCM_BITS  = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_l,
  el2_ifu_iccm_access_ctrl_if.slave bus
);
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {IDLE = 1'b0, CORR = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [SW-1:0]        starve_cnt;
  logic                 fetch_gnt, dma_gnt, in_corr, corr_dropped;
  logic                 fetch_win, fetch_err, corr_start;
  logic                 rden_q, wren_q, src1_q, buf_corr_q;
  logic [ICCM_BITS-1:1] addr_q, rd_addr_q;
  logic [2:0]           size_q;
  logic [77:0]          data_q;
  logic                 rd_valid_q, rd_src_q;
  logic [7:0]           corr_count_q;

  assign fetch_err  = rd_valid_q & ~rd_src_q & bus.ecc_single_err;
  assign corr_start = (state == IDLE) & fetch_err;
  assign fetch_win  = bus.fetch_req & (~bus.dma_req | (starve_cnt == STARVE_LIM));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fetch_err) state_nxt = CORR;
      CORR: state_nxt = IDLE;
    endcase
  end

  // Grants are withheld in the cycle a fetch error is seen so the correction
  // write owns the memory port on the following cycle.
  always_comb begin
    fetch_gnt    = 1'b0;
    dma_gnt      = 1'b0;
    in_corr      = 1'b0;
    corr_dropped = 1'b0;
    case (state)
      IDLE: begin
        if (rst_l && !fetch_err) begin
          if (fetch_win)        fetch_gnt = 1'b1;
          else if (bus.dma_req) dma_gnt   = 1'b1;
        end
      end
      CORR: begin
        in_corr      = 1'b1;
        corr_dropped = fetch_err;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                          starve_cnt <= '0;
    else if (fetch_gnt || !bus.fetch_req) starve_cnt <= '0;
    else if (dma_gnt && starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      src1_q       <= 1'b0;
      buf_corr_q   <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      data_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_src_q     <= 1'b0;
      rd_addr_q    <= '0;
      corr_count_q <= '0;
    end else begin
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      buf_corr_q <= 1'b0;
      if (corr_start) begin
        wren_q     <= 1'b1;
        buf_corr_q <= 1'b1;
        addr_q     <= rd_addr_q;
        size_q     <= 3'b011;
        data_q     <= bus.ecc_corr_data;
      end else if (fetch_gnt) begin
        rden_q <= 1'b1;
        src1_q <= 1'b0;
        addr_q <= bus.fetch_addr;
        size_q <= 3'b011;
        data_q <= '0;
      end else if (dma_gnt) begin
        rden_q <= ~bus.dma_write;
        wren_q <= bus.dma_write;
        src1_q <= 1'b1;
        addr_q <= bus.dma_addr;
        size_q <= bus.dma_size;
        data_q <= bus.dma_wdata;
      end
      rd_valid_q <= rden_q;
      rd_src_q   <= src1_q;
      rd_addr_q  <= addr_q;
      if (corr_start && corr_count_q != 8'hFF)
        corr_count_q <= corr_count_q + 8'd1;
    end
  end

  assign bus.fetch_gnt             = fetch_gnt;
  assign bus.dma_gnt               = dma_gnt;
  assign bus.rd_valid              = rd_valid_q;
  assign bus.rd_src                = rd_src_q;
  assign bus.iccm_rden             = rden_q;
  assign bus.iccm_wren             = wren_q;
  assign bus.iccm_rw_addr          = addr_q;
  assign bus.iccm_wr_size          = size_q;
  assign bus.iccm_wr_data          = data_q;
  assign bus.iccm_buf_correct_ecc  = buf_corr_q;
  assign bus.iccm_correction_state = in_corr;
  assign bus.corr_count            = corr_count_q;
  assign bus.corr_dropped          = corr_dropped;
endmodule
